uart_rx_mmio: RTL and testbench

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_mmio_if.sv | 34 +++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx_mmio.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the memory-mapped UART receiver.
//   rx_state_t      : receiver FSM state encoding
//   ST_* / CTRL_*   : bit positions inside the status and control bytes
//   FIFO_DEPTH      : receive buffer depth when UART_RX_FIFO_EN is defined
//   MID_SAMPLE      : oversample count at which the line is sampled
//   calc_div()      : oversample tick divider (rounded, never below 1)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Status byte (lane 0)
    localparam int ST_RX_VALID  = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_RX_BUSY   = 3;

    // Control byte (lane 3)
    localparam int CTRL_RX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam int FIFO_DEPTH = 4;

    localparam logic [3:0] MID_SAMPLE = 4'd7;

    // Number of clk cycles per 16x oversample tick, rounded to nearest.
    function automatic int calc_div(input int sys_clk, input int baud);
        int d;
        d = (sys_clk + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_rx_mmio_if
// Memory-mapped bus bundle for the UART receiver.
//   memAddress    : byte address            (master -> slave)
//   memWriteData  : write data, lane aligned (master -> slave)
//   memWrite      : write strobe             (master -> slave)
//   byteMask      : per-lane write enable    (master -> slave)
//   memReadData   : registered read data     (slave -> master)
// ---------------------------------------------------------------------------
interface uart_rx_mmio_if;

    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;

    modport master (
        output memAddress,
        output memWriteData,
        output memWrite,
        output byteMask,
        input  memReadData
    );

    modport slave (
        input  memAddress,
        input  memWriteData,
        input  memWrite,
        input  byteMask,
        output memReadData
    );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running 16x oversample enable. tick is high for one clk cycle every
// calc_div(SYS_CLK_FREQ, BAUD_RATE) cycles; it is a clock enable, not a clock.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   tick    : one-cycle oversample enable
// ---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 9000000,
    parameter int BAUD_RATE    = 115200
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_mmio.sv
// ---------------------------------------------------------------------------
// uart_rx_mmio
// 8N1 UART receiver with a small memory-mapped register window.
//   Map (one 32-bit word, lanes selected by byteMask on writes):
//     [7:0]   status  : rx_valid, overrun, framing_err, rx_busy (RO)
//     [15:8]  rx data : head of receive buffer; writing this lane pops (RO)
//     [23:16] reserved, reads 0
//     [31:24] control : rx_en, irq_en, clr_err (self-clearing)
//   Build option: define UART_RX_FIFO_EN for a 4-entry receive FIFO;
//   otherwise a single holding register is used.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   memAddress     : bus byte address
//   memWriteData   : write data
//   memWrite       : write strobe
//   byteMask       : per-lane write enable
//   memReadData    : registered read data (0 for out-of-range addresses)
//   uart_rx        : serial input, idle high
//   rx_irq         : rx_valid AND irq_en
// ---------------------------------------------------------------------------
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFF0,
    parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFF3,
    parameter int          SYS_CLK_FREQ = 9000000,
    parameter int          BAUD_RATE    = 115200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
    input  logic        uart_rx,
    output logic        rx_irq
);

    // Internal view of the bus as the slave side of the shared bundle.
    uart_rx_mmio_if bus_if ();

    assign bus_if.memAddress   = memAddress;
    assign bus_if.memWriteData = memWriteData;
    assign bus_if.memWrite     = memWrite;
    assign bus_if.byteMask     = byteMask;
    assign memReadData         = bus_if.memReadData;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic in_range;
    logic ctrl_wr;
    logic pop_req;
    logic clr_err;

    assign in_range = (bus_if.memAddress >= BASE_MEMORY) &&
                      (bus_if.memAddress <= TOP_MEMORY);
    assign ctrl_wr  = bus_if.memWrite && in_range && bus_if.byteMask[3];
    assign pop_req  = bus_if.memWrite && in_range && bus_if.byteMask[1];
    assign clr_err  = ctrl_wr && bus_if.memWriteData[24 + CTRL_CLR_ERR];

    // Lanes that carry no writable state.
    logic unused_bits;
    assign unused_bits = ^{bus_if.memWriteData[31:27], bus_if.memWriteData[23:0],
                           bus_if.byteMask[2], bus_if.byteMask[0]};

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_prev_q;
    logic       rx_s;
    logic       rx_fall;

    assign rx_s    = sync_q[1];
    assign rx_fall = rx_prev_q && !rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------
    logic tick;

    uart_baud_tick #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done;
    logic       stop_bad;
    logic       mid_sample;
    logic       rx_en_q;
    logic       irq_en_q;

    // The 4-bit counter wraps every 16 ticks, so after the start-bit
    // mid-sample at count 7 every later count 7 lands one bit later.
    assign mid_sample = tick && (tick_cnt_q == MID_SAMPLE);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;

        if (state_q != IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                // rx_en only gates the start of a frame; a frame in flight
                // always runs to completion.
                if (rx_en_q && rx_fall) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                end
            end
            START: begin
                if (mid_sample) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (mid_sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (mid_sample) begin
                    byte_done = 1'b1;
                    stop_bad  = !rx_s;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    logic       rx_valid;
    logic       buf_full;
    logic [7:0] head_data;
    logic       do_pop;
    logic       do_push;
    logic       drop;

    // A pop in the same cycle as a completion frees the slot being filled,
    // so a full buffer still accepts the new byte.
    assign do_pop  = pop_req && rx_valid;
    assign do_push = byte_done && (!buf_full || do_pop);
    assign drop    = byte_done && buf_full && !do_pop;

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // Storage has no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_valid  = (count_q != '0);
    assign buf_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign head_data = fifo_mem[rd_ptr_q];
`else
    logic [7:0] hold_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            if (do_push) begin
                hold_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (do_pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid  = valid_q;
    assign buf_full  = valid_q;
    assign head_data = hold_q;
`endif

    // ------------------------------------------------------------------
    // Control and sticky error flags
    // ------------------------------------------------------------------
    logic overrun_q;
    logic frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_en_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rx_en_q  <= bus_if.memWriteData[24 + CTRL_RX_EN];
                irq_en_q <= bus_if.memWriteData[24 + CTRL_IRQ_EN];
            end
            // A new error event in the clearing cycle is kept, not lost.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
            if (byte_done && stop_bad) begin
                frame_err_q <= 1'b1;
            end else if (clr_err) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign rx_irq = rx_valid && irq_en_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0]  status_byte;
    logic [7:0]  ctrl_byte;
    logic [7:0]  data_byte;
    logic [31:0] rd_data_q, rd_data_d;

    always_comb begin
        status_byte               = 8'h00;
        status_byte[ST_RX_VALID]  = rx_valid;
        status_byte[ST_OVERRUN]   = overrun_q;
        status_byte[ST_FRAME_ERR] = frame_err_q;
        status_byte[ST_RX_BUSY]   = (state_q != IDLE);

        ctrl_byte              = 8'h00;
        ctrl_byte[CTRL_RX_EN]  = rx_en_q;
        ctrl_byte[CTRL_IRQ_EN] = irq_en_q;

        // An empty buffer reads as 0 rather than exposing stale storage.
        data_byte = rx_valid ? head_data : 8'h00;

        rd_data_d = 32'h0;
        if (in_range) begin
            rd_data_d = {ctrl_byte, 8'h00, data_byte, status_byte};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 32'h0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus_if.memReadData = rd_data_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] TOP  = 32'hFFFF_FFF3;
    localparam int BIT      = 78;   // 9 MHz / 115200 baud
    localparam int IDLE_GAP = 20;
    localparam int DIV      = 5;

    logic clk = 1'b0;
    logic reset_n;
    logic uart_rx;
    logic rx_irq;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_rx_mmio_if bus_if ();

    uart_rx_mmio dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .memAddress   (bus_if.memAddress),
        .memWriteData (bus_if.memWriteData),
        .memWrite     (bus_if.memWrite),
        .byteMask     (bus_if.byteMask),
        .memReadData  (bus_if.memReadData),
        .uart_rx      (uart_rx),
        .rx_irq       (rx_irq)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release; the baud divider shares this phase.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_if.memAddress   = a;
        bus_if.memWriteData = d;
        bus_if.byteMask     = m;
        bus_if.memWrite     = 1'b1;
        @(negedge clk);
        bus_if.memWrite     = 1'b0;
        bus_if.byteMask     = 4'b0000;
        bus_if.memAddress   = BASE;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_if.memAddress = a;
        @(negedge clk);
        check_eq(tag, bus_if.memReadData, exp);
        bus_if.memAddress = BASE;
    endtask

    task automatic pop();
        bus_write(BASE, 32'h0, 4'b0010);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (IDLE_GAP) @(negedge clk);
    endtask

    task automatic align();
        while (cyc % DIV != 0) @(negedge clk);
    endtask

    int          cal_start, cal_obs, k_off, st;
    bit          cal_seen;
    logic [7:0]  fill [4];
    logic [7:0]  pb;
    int          n_fill;

    initial begin
        reset_n             = 1'b0;
        uart_rx             = 1'b1;
        bus_if.memAddress   = BASE;
        bus_if.memWriteData = 32'h0;
        bus_if.memWrite     = 1'b0;
        bus_if.byteMask     = 4'b0000;
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_RX_FIFO_EN
        n_fill = 4;
`else
        n_fill = 1;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_rdata", bus_if.memReadData, 32'h0);
        check_eq("rst_irq", rx_irq, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk("idle_map", BASE, 32'h0000_0000);

        // Enable receiver, receive 0xA5
        bus_write(BASE, 32'h0100_0000, 4'b1000);
        rd_chk("ctrl_rx_en", BASE, 32'h0100_0000);
        send_byte(8'hA5, 1'b1);
        rd_chk("rx_a5", BASE, 32'h0100_A501);
        rd_chk("rd_top", TOP, 32'h0100_A501);
        rd_chk("rd_below", BASE - 32'd1, 32'h0);
        rd_chk("rd_above", TOP + 32'd1, 32'h0);
        check_eq("irq_off", rx_irq, 32'h0);
        bus_write(BASE, 32'h0300_0000, 4'b1000);
        check_eq("irq_on", rx_irq, 32'h1);
        pop();
        rd_chk("pop_a5", BASE, 32'h0300_0000);
        check_eq("irq_after_pop", rx_irq, 32'h0);
        pop();
        rd_chk("pop_empty", BASE, 32'h0300_0000);

        // Three-tick low glitch: brief busy, then back to idle with nothing stored
        uart_rx = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("glitch_busy", bus_if.memReadData, 32'h0300_0008);
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        rd_chk("glitch_idle", BASE, 32'h0300_0000);

        // Framing error: stop bit low
        send_byte(8'h3C, 1'b0);
        rd_chk("frame_err", BASE, 32'h0300_3C05);
        bus_write(BASE, 32'h0700_0000, 4'b1000);
        rd_chk("clr_err", BASE, 32'h0300_3C01);
        pop();
        rd_chk("pop_3c", BASE, 32'h0300_0000);

        // Overrun
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        rd_chk("ovr_head1", BASE, 32'h0300_0103);
        for (int i = 2; i <= 4; i++) begin
            pop();
            rd_chk("ovr_head", BASE, {8'h03, 8'h00, 8'(i), 8'h03});
        end
        pop();
        rd_chk("ovr_empty", BASE, 32'h0300_0002);
`else
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        rd_chk("ovr_hold", BASE, 32'h0300_0103);
        pop();
        rd_chk("ovr_empty", BASE, 32'h0300_0002);
`endif
        bus_write(BASE, 32'h0700_0000, 4'b1000);
        rd_chk("ovr_clr", BASE, 32'h0300_0000);

        // Locate the completion edge relative to a tick-aligned frame start
        align();
        cal_start = cyc;
        cal_seen  = 1'b0;
        cal_obs   = 0;
        fork
            send_byte(8'h77, 1'b1);
            begin
                for (int n = 0; n < 2000 && !cal_seen; n++) begin
                    @(negedge clk);
                    if (bus_if.memReadData[0]) begin
                        cal_seen = 1'b1;
                        cal_obs  = cyc;
                    end
                end
            end
        join
        check_eq("cal_seen", 32'(cal_seen), 32'h1);
        k_off = cal_seen ? (cal_obs - 1 - cal_start) : 800;
        rd_chk("cal_77", BASE, 32'h0300_7701);
        pop();

        // Fill the buffer, then pop exactly on the completion edge
        for (int i = 0; i < n_fill; i++) send_byte(fill[i], 1'b1);
        align();
        st = cyc;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (cyc < st + k_off - 1) @(negedge clk);
                bus_if.memWrite = 1'b1;
                bus_if.byteMask = 4'b0010;
                @(negedge clk);
                bus_if.memWrite = 1'b0;
                bus_if.byteMask = 4'b0000;
            end
        join
`ifdef UART_RX_FIFO_EN
        rd_chk("coinc_head22", BASE, 32'h0300_2201);
        pop();
        rd_chk("coinc_head33", BASE, 32'h0300_3301);
        pop();
        rd_chk("coinc_head44", BASE, 32'h0300_4401);
        pop();
        rd_chk("coinc_head55", BASE, 32'h0300_5501);
`else
        rd_chk("coinc_head55", BASE, 32'h0300_5501);
`endif
        pop();
        rd_chk("coinc_empty", BASE, 32'h0300_0000);

        // Reset in the middle of a frame (during data bit 4)
        send_byte(8'hE7, 1'b1);
        check_eq("irq_pre_rst", rx_irq, 32'h1);
        pb = 8'hC3;
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = pb[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = pb[4];
        repeat (BIT / 2) @(negedge clk);
        rd_chk("busy_mid", BASE, 32'h0300_E709);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("midrst_rdata", bus_if.memReadData, 32'h0);
        check_eq("midrst_irq", rx_irq, 32'h0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        rd_chk("post_rst", BASE, 32'h0000_0000);
        bus_write(BASE, 32'h0100_0000, 4'b1000);
        send_byte(8'h5A, 1'b1);
        rd_chk("rx_5a", BASE, 32'h0100_5A01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
